// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with a registered one-hot grant, encoded grant index
// and per-client burst credit; the last owner is always scanned last.
module wrr_arbiter #(
  parameter int  CLIENTS  = 32,
  parameter int  WEIGHT_W = 4,
  localparam int IDX_W    = $clog2(CLIENTS)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [CLIENTS-1:0]          request,
  input  logic [CLIENTS*WEIGHT_W-1:0] weight,
  input  logic                        stall,
  output logic [CLIENTS-1:0]          grant,
  output logic [IDX_W-1:0]            grant_id,
  output logic                        grant_valid
);

  logic [CLIENTS-1:0]  r_grant;
  logic [IDX_W-1:0]    r_grant_id;
  logic                r_grant_valid;
  logic [IDX_W-1:0]    r_owner;
  logic [WEIGHT_W-1:0] r_credit;
  logic                r_stall_rec;

  logic [WEIGHT_W-1:0] w_wt [CLIENTS];
  logic [IDX_W-1:0]    w_idx;
  logic [IDX_W-1:0]    w_winner;
  logic                w_found;
  logic                w_hold;

  function automatic logic [CLIENTS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [CLIENTS-1:0] v;
    v      = {CLIENTS{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Unpack the flat weight bus into one field per client.
  always_comb begin
    for (int i = 0; i < CLIENTS; i++) begin
      w_wt[i] = weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  // Rotating priority scan starting just after the owner, with the owner itself last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = {IDX_W{1'b0}};
    w_idx    = {IDX_W{1'b0}};
    for (int i = 1; i <= CLIENTS; i++) begin
      w_idx    = IDX_W'((int'(r_owner) + i) % CLIENTS);
      w_winner = (request[w_idx] && !w_found) ? w_idx : w_winner;
      w_found  = w_found | request[w_idx];
    end
  end

  // The stall-recovery flag lets the owner resume its burst although the grant was cleared.
  assign w_hold = (r_grant_valid | r_stall_rec) & request[r_owner] &
                  (r_credit != {WEIGHT_W{1'b0}});

  // Arbitration state and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_grant       <= {CLIENTS{1'b0}};
      r_grant_id    <= {IDX_W{1'b0}};
      r_grant_valid <= 1'b0;
      r_owner       <= IDX_W'(CLIENTS - 1);
      r_credit      <= {WEIGHT_W{1'b0}};
      r_stall_rec   <= 1'b0;
    end else if (stall) begin
      r_grant       <= {CLIENTS{1'b0}};
      r_grant_id    <= {IDX_W{1'b0}};
      r_grant_valid <= 1'b0;
      r_stall_rec   <= 1'b1;
    end else begin
      r_stall_rec <= 1'b0;
      if (w_hold) begin
        r_grant       <= onehot(r_owner);
        r_grant_id    <= r_owner;
        r_grant_valid <= 1'b1;
        r_credit      <= r_credit - {{(WEIGHT_W-1){1'b0}}, 1'b1};
      end else if (w_found) begin
        r_grant       <= onehot(w_winner);
        r_grant_id    <= w_winner;
        r_grant_valid <= 1'b1;
        r_owner       <= w_winner;
        r_credit      <= w_wt[w_winner];
      end else begin
        r_grant       <= {CLIENTS{1'b0}};
        r_grant_id    <= {IDX_W{1'b0}};
        r_grant_valid <= 1'b0;
      end
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_valid = r_grant_valid;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed self-checking bench for wrr_arbiter with four clients and hand-computed grant sequences.
module tb_wrr_arbiter;

  localparam int CLIENTS  = 4;
  localparam int WEIGHT_W = 4;

  logic                        clock;
  logic                        reset_n;
  logic [CLIENTS-1:0]          request;
  logic [CLIENTS*WEIGHT_W-1:0] weight;
  logic                        stall;
  logic [CLIENTS-1:0]          grant;
  logic [1:0]                  grant_id;
  logic                        grant_valid;

  int n_checks = 0;
  int n_fail   = 0;

  wrr_arbiter #(.CLIENTS(CLIENTS), .WEIGHT_W(WEIGHT_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .request     (request),
    .weight      (weight),
    .stall       (stall),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // id is ignored when valid is 0: an idle grant must read all-zero.
  task automatic expect_gnt(input string tag, input int id, input bit valid);
    logic [31:0] exp_g;
    logic [31:0] exp_id;
    exp_g  = 32'd0;
    exp_id = 32'd0;
    if (valid) begin
      exp_g[id] = 1'b1;
      exp_id    = 32'(id);
    end
    check_eq({tag, "_grant"}, 32'(grant), exp_g);
    check_eq({tag, "_id"}, 32'(grant_id), exp_id);
    check_eq({tag, "_valid"}, 32'(grant_valid), 32'(valid));
  endtask

  // Pulse reset between edges and confirm the outputs clear without a clock edge.
  task automatic pulse_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    expect_gnt({tag, "_async"}, 0, 1'b0);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    request = 4'b0000;
    weight  = 16'h0000;
    stall   = 1'b0;
    tick();

    // Plain round-robin with all weights zero.
    pulse_reset("rst");
    request = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_gnt($sformatf("rr%0d", i), i % 4, 1'b1);
    end

    // Weights client3..0 = 3,0,1,0 with clients 0 and 3 requesting.
    pulse_reset("wb");
    weight  = {4'd3, 4'd0, 4'd1, 4'd0};
    request = 4'b1001;
    begin
      int seq [8] = '{0, 3, 3, 3, 3, 0, 3, 3};
      for (int i = 0; i < 8; i++) begin
        tick();
        expect_gnt($sformatf("wb%0d", i), seq[i], 1'b1);
      end
    end

    // Client 2 drops its request after two grant cycles; client 1 follows bubble-free.
    pulse_reset("er");
    weight  = {4'd0, 4'd7, 4'd0, 4'd0};
    request = 4'b0100;
    tick(); expect_gnt("er0", 2, 1'b1);
    tick(); expect_gnt("er1", 2, 1'b1);
    request = 4'b0010;
    tick(); expect_gnt("er2", 1, 1'b1);
    tick(); expect_gnt("er3", 1, 1'b1);

    // Client 1 stalled with credit 2 resumes for exactly two cycles, then client 2.
    pulse_reset("st");
    weight  = {4'd0, 4'd0, 4'd3, 4'd0};
    request = 4'b0110;
    tick(); expect_gnt("st0", 1, 1'b1);
    tick(); expect_gnt("st1", 1, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_gnt($sformatf("st_stall%0d", i), 0, 1'b0);
    end
    stall = 1'b0;
    tick(); expect_gnt("st_rec0", 1, 1'b1);
    tick(); expect_gnt("st_rec1", 1, 1'b1);
    tick(); expect_gnt("st_next", 2, 1'b1);
    tick(); expect_gnt("st_wrap", 1, 1'b1);

    // Sole requester with weight 1, then idle; owner 3 retained so client 0 wins next.
    pulse_reset("so");
    weight  = {4'd1, 4'd0, 4'd0, 4'd0};
    request = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_gnt($sformatf("so%0d", i), 3, 1'b1);
    end
    request = 4'b0000;
    tick(); expect_gnt("so_idle", 0, 1'b0);
    request = 4'b1001;
    tick(); expect_gnt("so_after", 0, 1'b1);

    // Asynchronous reset in the middle of a long burst.
    pulse_reset("ar_pre");
    weight  = {4'd0, 4'd7, 4'd0, 4'd0};
    request = 4'b0100;
    tick(); expect_gnt("ar0", 2, 1'b1);
    tick(); expect_gnt("ar1", 2, 1'b1);
    pulse_reset("ar_mid");
    request = 4'b1111;
    tick(); expect_gnt("ar_first", 0, 1'b1);
    tick(); expect_gnt("ar_second", 1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
